// File: rtl/mc_sequencer.sv
// mc_sequencer: multicycle control sequencer for the MIPS-subset datapath.
// The sequencer fetches a word over a ready/valid handshake, latches it into an
// instruction register and steps through FETCH, DECODE, EXEC, ADDR, MEM and WB.
// All datapath strobes are Moore outputs, decoded from state_q and the latched word.
// Handshake: a word transfers on a rising edge where instr_valid and instr_ready
// are both high. instr_ready is high only in FETCH. dmem_ack is honoured only in MEM.
// Optional feature: define RETIRE_CNT_EN to build the CNT_W-bit retired-instruction
// counter. Without the macro, retire_count is tied to zero.
module mc_sequencer #(
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             instr_valid,
    input  logic [31:0]      instruction,
    output logic             instr_ready,
    output logic             pc_inc,
    input  logic             dmem_ack,
    output logic             dmem_req,
    output logic [2:0]       alu_op,
    output logic             alu_src_imm,
    output logic             reg_we,
    output logic             reg_dst_rd,
    output logic             mem_to_reg,
    output logic             retired,
    output logic             illegal,
    output logic             busy,
    output logic [CNT_W-1:0] retire_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_ADDR   = 3'd4,
        S_MEM    = 3'd5,
        S_WB     = 3'd6
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;

    // EXEC runs until the counter reads zero, so MUL loads one less than its cycle count.
    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [3:0]  cnt_q, cnt_d;

    logic       dec_rtype;
    logic       dec_lw;
    logic       dec_mul;
    logic       dec_illegal;
    logic [2:0] dec_op;

    // Only the opcode and funct fields steer the sequencer; the register and
    // offset fields go straight to the datapath.
    logic unused_ir_fields;
    assign unused_ir_fields = ^ir_q[25:6];

    // Decode the latched instruction word (never the live bus) into class and ALU op.
    always_comb begin
        dec_rtype = 1'b0;
        dec_lw    = 1'b0;
        dec_mul   = 1'b0;
        dec_op    = OP_ADD;
        if (ir_q[31:26] == 6'b001111) begin
            dec_rtype = 1'b1;
            case (ir_q[5:0])
                6'b100000: dec_op = OP_ADD;
                6'b100010: dec_op = OP_SUB;
                6'b110010: begin
                    dec_op  = OP_MUL;
                    dec_mul = 1'b1;
                end
                6'b100100: dec_op = OP_AND;
                6'b100101: dec_op = OP_OR;
                default:   dec_rtype = 1'b0;
            endcase
        end else if (ir_q[31:27] == 5'b01000) begin
            dec_lw = 1'b1;
        end
    end

    assign dec_illegal = !(dec_rtype || dec_lw);

    // Next-state, instruction-register and MUL-counter update plus Moore strobes.
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        cnt_d       = cnt_q;
        instr_ready = 1'b0;
        pc_inc      = 1'b0;
        dmem_req    = 1'b0;
        alu_op      = OP_ADD;
        alu_src_imm = 1'b0;
        reg_we      = 1'b0;
        reg_dst_rd  = 1'b0;
        mem_to_reg  = 1'b0;
        retired     = 1'b0;
        illegal     = 1'b0;
        busy        = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    ir_d    = instruction;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // The PC advance is reported one cycle after the accept edge.
                pc_inc = 1'b1;
                if (dec_illegal) begin
                    illegal = 1'b1;
                    state_d = run ? S_FETCH : S_IDLE;
                end else if (dec_rtype) begin
                    cnt_d   = dec_mul ? MUL_LOAD : 4'd0;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_ADDR;
                end
            end
            S_EXEC: begin
                alu_op = dec_op;
                if (cnt_q == 4'd0) begin
                    state_d = S_WB;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ADDR: begin
                alu_src_imm = 1'b1;
                state_d     = S_MEM;
            end
            S_MEM: begin
                dmem_req    = 1'b1;
                alu_src_imm = 1'b1;
                if (dmem_ack) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                reg_we     = 1'b1;
                retired    = 1'b1;
                reg_dst_rd = dec_rtype;
                mem_to_reg = dec_lw;
                state_d    = run ? S_FETCH : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, instruction register and MUL counter; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef RETIRE_CNT_EN
    logic [CNT_W-1:0] rcnt_q, rcnt_d;

    // Count each write-back cycle; illegal instructions never reach WB. Wraps naturally.
    always_comb begin
        rcnt_d = rcnt_q;
        if (state_q == S_WB) begin
            rcnt_d = rcnt_q + CNT_W'(1);
        end
    end

    // Retired-instruction counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt_q <= '0;
        end else begin
            rcnt_q <= rcnt_d;
        end
    end

    assign retire_count = rcnt_q;
`else
    assign retire_count = '0;
`endif

endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
- Multicycle sequencer for the MIPS-subset datapath.
- Fetches instructions over a ready/valid handshake, latches them, and decodes the group/funct fields.
- Drives per-cycle datapath strobes (ALU op, operand select, register write, data-memory request) through FETCH, DECODE, EXEC, ADDR, MEM and WB.
- Sits between instruction memory, data memory, and the register file/ALU datapath.

Parameters:
- MUL_CYCLES, 4, number of EXEC cycles held for MUL (legal range 1..15).
- CNT_W, 16, width of the retired-instruction counter (optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  enables fetching of new instructions.
- instr_valid  in  1  instruction memory presents a word.
- instruction  in  32  instruction word.
- instr_ready  out  1  sequencer accepts an instruction (FETCH state).
- pc_inc  out  1  one-cycle pulse: advance PC.
- dmem_ack  in  1  data memory has completed the read.
- dmem_req  out  1  data memory read request.
- alu_op  out  3  000 ADD, 001 SUB, 010 MUL, 011 AND, 100 OR.
- alu_src_imm  out  1  ALU B operand = sign-extended offset [15:0].
- reg_we  out  1  register file write enable.
- reg_dst_rd  out  1  write address select: 1 = rd [15:11], 0 = rt [20:16].
- mem_to_reg  out  1  write-back data comes from data memory.
- retired  out  1  one-cycle pulse in WB.
- illegal  out  1  one-cycle pulse on an undecodable instruction.
- busy  out  1  high in every state except IDLE.
- retire_count  out  CNT_W  retired-instruction count (see Optional Feature).

Behaviour:
- Reset: state returns to IDLE; the instruction register and MUL counter clear to 0.
- All outputs are 0 during reset and in IDLE. All outputs are decoded from registered state (Moore).
- Decoding is done from the internal instruction register, never from the live instruction input.
- Opcode [31:26] = 6'b001111 is R-type. funct [5:0] decodes as:
  - 100000 ADD
  - 100010 SUB
  - 110010 MUL
  - 100100 AND
  - 100101 OR
  - any other funct is illegal.
- Opcode 6'b010000 or 6'b010001 is LW. Every other opcode is illegal.
- State transitions:
  - IDLE: if run=1, go to FETCH.
  - FETCH: instr_ready=1. On instr_valid & instr_ready, latch the instruction, pulse pc_inc, go to DECODE. Otherwise stay in FETCH indefinitely.
  - DECODE (1 cycle):
    - illegal: pulse illegal, go to FETCH if run else IDLE.
    - R-type: go to EXEC and load the MUL counter with MUL_CYCLES-1 if MUL, else 0.
    - LW: go to ADDR.
  - EXEC: alu_op = decoded op, alu_src_imm=0. Decrement the counter each cycle and go to WB when it is 0. Non-MUL ops therefore take 1 EXEC cycle; MUL takes exactly MUL_CYCLES.
  - ADDR (1 cycle): alu_op=ADD, alu_src_imm=1, then go to MEM.
  - MEM: dmem_req=1, alu_op=ADD, alu_src_imm=1, held until dmem_ack. On the cycle dmem_ack=1, go to WB. No timeout.
  - WB (1 cycle): reg_we=1, retired=1.
    - R-type: reg_dst_rd=1, mem_to_reg=0.
    - LW: reg_dst_rd=0, mem_to_reg=1.
    - Then go to FETCH if run else IDLE.
- Instruction latency from accept to retire:
  - ADD/SUB/AND/OR: 3 cycles (DECODE, EXEC, WB).
  - MUL: 2+MUL_CYCLES cycles.
  - LW: 4 cycles plus MEM wait cycles.
- run deasserted mid-instruction: the current instruction completes through WB, then the sequencer goes to IDLE. run is sampled only in IDLE, DECODE (illegal path) and WB.
- instr_valid outside FETCH is ignored. dmem_ack outside MEM is ignored.
- Asynchronous reset mid-operation aborts the instruction with no write-back and no retired pulse.

Optional Feature:
- Macro: RETIRE_CNT_EN.
- Defined: retire_count is a CNT_W-bit register, reset to 0, incremented on every retired pulse. It wraps from all-ones to 0. Illegal instructions are not counted.
- Not defined: retire_count is tied to 0 and no counter flops are instantiated.

Test Plan:
- LW: run=1; instruction 32'h40010000 with instr_valid held high; dmem_ack asserted 2 cycles after dmem_req rises.
  - Expect pc_inc pulse, ADDR with alu_src_imm=1, dmem_req for exactly 3 cycles.
  - Expect WB with reg_we=1, reg_dst_rd=0, mem_to_reg=1, retired=1.
- ADD then SUB: 32'h3C221A20 followed by 32'h3C221A22.
  - Expect each to retire 3 cycles after accept.
  - Expect alu_op 000 then 001, reg_dst_rd=1 in WB.
- MUL: 32'h3C221A32 with MUL_CYCLES=4.
  - Expect alu_op=010 held for exactly 4 cycles, then WB; retired 6 cycles after accept.
- Illegal instructions: 32'h3C221A3F (bad funct) and 32'hFC000000 (bad opcode).
  - Expect illegal pulse in DECODE, no reg_we or retired, return to FETCH.
- run dropped and reset mid-operation:
  - Deassert run during MEM of LW 32'h44030003: expect the LW completes, then IDLE with busy=0.
  - Separately, pulse rst_n low during MUL EXEC: expect immediate IDLE, all outputs 0, no retired pulse.
- RETIRE_CNT_EN defined, CNT_W=4: retire 17 ADDs.
  - Expect retire_count = 1 (wrap).
  - An illegal instruction does not change the count.
